// File: rtl/shift_add_mult4_pkg.sv
// Shared constants for the shift-and-add 4x4 multiplier.
package shift_add_mult4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration count value on which the final product is written.
  localparam logic [1:0] ITER_LAST = 2'd3;

endpackage

// File: rtl/shift_add_mult4_if.sv
// Start/done handshake and operand/product bus for the multiplier.
interface shift_add_mult4_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/shift_add_mult4_adder.sv
// 4-bit ripple-carry adder used as the multiplier's per-iteration datapath.
module binary4bitadder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic [4:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o = c[4];
endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier around a 4-bit ripple adder.
module shift_add_mult4
  import shift_add_mult4_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  shift_add_mult4_if.slave bus
);
  state_e     state_q, state_d;
  logic [3:0] ra_q, acc_q, q_q;
  logic [1:0] cnt_q;
  logic [7:0] p_q;
  logic [3:0] addend, sum;
  logic       co;
  logic       busy, done;

  // A new operation is accepted whenever the FSM is not iterating.
  logic accept;
  assign accept = bus.start && (state_q != ST_BUSY);

  // Partial-product select: add the multiplicand only when the current LSB is set.
  assign addend = q_q[0] ? ra_q : 4'b0;

  binary4bitadder u_add (
    .a_i  (acc_q),
    .b_i  (addend),
    .cin_i(1'b0),
    .s_o  (sum),
    .co_o (co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: four iterations in BUSY, DONE may chain straight into a new op.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == ITER_LAST) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_BUSY: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, shift-add iteration and product write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q  <= 4'h0;
      acc_q <= 4'h0;
      q_q   <= 4'h0;
      cnt_q <= 2'd0;
      p_q   <= 8'h00;
    end else if (state_q == ST_BUSY) begin
      // {co,sum} is the 5-bit partial high; shift it right into q.
      acc_q <= {co, sum[3:1]};
      q_q   <= {sum[0], q_q[3:1]};
      cnt_q <= cnt_q + 2'd1;
      if (cnt_q == ITER_LAST) p_q <= {co, sum, q_q[3:1]};
    end else if (accept) begin
      ra_q  <= bus.a;
      q_q   <= bus.b;
      acc_q <= 4'h0;
      cnt_q <= 2'd0;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.p    = p_q;
endmodule
